gsensor_ctrl: RTL and testbench
===============================

# gsensor_ctrl

Upstream sequencer for `spi_serdes` on the DE10-Lite accelerometer (ADXL345) path. After reset it writes a fixed three-register init table, then periodically polls INT_SOURCE. When DATA_READY is set it reads the six axis bytes and publishes signed 16-bit X/Y/Z samples with a one-cycle valid strobe. It runs in the `spi_clk` domain and connects directly to `spi_serdes` `data_tx`, `start`, `done` and `data_rx`.

## Interface
- `STARTUP_CYCLES`, 4000: idle cycles after reset before the first transaction (2 ms at 2 MHz).
- `POLL_CYCLES`, 40000: cycles between the end of one poll and the next status read (20 ms at 2 MHz).
- `TIMEOUT_CYCLES`, 256: maximum cycles to wait for `done` to rise, or to fall.
- `spi_clk`  in  1: sole clock; the same clock that drives `spi_serdes`.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `data_tx`  out  16: transaction word to serdes; `[15]`=1 means read, `[13:8]` = register address, `[7:0]` = write data (0x00 on reads).
- `start`  out  1: transaction request to serdes.
- `done`  in  1: transaction complete from serdes.
- `data_rx`  in  8: read byte from serdes; valid while `done`=1.
- `data_x`, `data_y`, `data_z`  out  16 each: latest sample, two's complement.
- `data_valid`  out  1: one-cycle pulse when all three axes update together.
- `init_done`  out  1: high once the init table is written; cleared on timeout.
- `error`  out  1: sticky flag, set on any handshake timeout; cleared only by reset.

## Operation
- **Reset values:** all outputs 0, including `start`, `data_tx` and `data_valid`.
- **Handshake with serdes (four-phase):**
  - Drive `data_tx` and raise `start`; `data_tx` stays stable while `start`=1.
  - Hold `start` until `done`=1. On that edge, capture `data_rx` if the transaction is a read, and drop `start`.
  - Wait for `done`=0 before launching the next transaction.
- **Timeout:** if either wait exceeds `TIMEOUT_CYCLES`:
  - drop `start`, set `error`, clear `init_done`;
  - return to STARTUP, which re-runs the full init.
- **Init table (in order):**
  - 0x2C ← 0x09 (BW_RATE, 50 Hz)
  - 0x31 ← 0x08 (DATA_FORMAT, full resolution)
  - 0x2D ← 0x08 (POWER_CTL, measure)
- **States and transitions:**
  - STARTUP: count to `STARTUP_CYCLES`.
  - INIT: issue 3 transactions; raise `init_done` after the last one completes.
  - POLL_WAIT: count to `POLL_CYCLES`.
  - STATUS: read 0x30.
    - If bit 7 = 0, go to POLL_WAIT and restart its counter.
    - If bit 7 = 1, go to READ.
  - READ: issue 6 reads, addresses 0x32 to 0x37 ascending, into shadow bytes.
  - PUBLISH: for one cycle:
    - `data_x` = {b[0x33], b[0x32]}
    - `data_y` = {b[0x35], b[0x34]}
    - `data_z` = {b[0x37], b[0x36]}
    - `data_valid` = 1
    - then go to POLL_WAIT.
- **Output stability:** axis outputs change only in PUBLISH. A timeout partway through READ leaves the previous sample intact.

## Timing
- First `start` rises `STARTUP_CYCLES`+1 cycles after `reset_n` deasserts.
- `start` falls one cycle after `done` is sampled high.
- The next `start` rises one cycle after `done` is sampled low.
- `data_valid` is asserted the cycle after the 6th read's `done` is sampled.
- Poll period: `POLL_CYCLES` plus transaction time (status read, plus 6 reads when data is ready).
- If `done`=1 is seen while `start`=0 (spurious), ignore it.
- If `reset_n` asserts mid-transaction, `start` drops immediately (asynchronously) and the sequencer re-enters STARTUP.
- Counters are `$clog2(max+1)` bits wide and saturate; they never wrap.

## Structure
- **`gsensor_pkg` (shared):**
  - register addresses: BW_RATE, DATA_FORMAT, POWER_CTL, INT_SOURCE, DATAX0 to DATAZ1;
  - init table (address/value pairs);
  - state encodings;
  - DATA_READY bit index (7).
- **`gsensor_txn` (sub-module):**
  - four-phase `start`/`done` handshake plus timeout counter;
  - interface: `req`/`addr`/`wdata`/`rnw` in; `ack`/`rdata`/`timeout` out;
  - `gsensor_ctrl` keeps the top-level sequencing FSM.

## Test plan
Benches pair the DUT with `spi_serdes` and `spi_secondary_mimic` (scripted responses).
- **Reset/init:** release reset → no `start` for 4000 cycles; then `data_tx` = 0x2C09, 0x3108, 0x2D08 in order; then `init_done`=1.
- **Not ready:** status returns 0x00 → no `data_valid`; next status read follows after `POLL_CYCLES`.
- **Sample read:** status 0x80, bytes 0x34,0x12,0xFF,0xFF,0x00,0x01 → one pulse with X=0x1234, Y=0xFFFF (−1), Z=0x0100.
- **Timeout:** stub holds `done`=0 during the 3rd read → after 256 cycles `start`=0, `error`=1, `init_done`=0; axis outputs unchanged; init replays.
- **Mid-transaction reset:** assert `reset_n`=0 while `start`=1 → all outputs 0 at once; full init sequence on release.
- **Back-to-back polls:** 3 consecutive ready polls → exactly 3 `data_valid` pulses, no `start` overlap; `data_tx` is stable whenever `start`=1.

Source files
------------

// File: rtl/gsensor_pkg.sv
// Shared definitions for the ADXL345 sequencer: register map, init table,
// state encodings and the transaction word layout used by spi_serdes.
package gsensor_pkg;

  localparam logic [5:0] REG_BW_RATE     = 6'h2C;
  localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
  localparam logic [5:0] REG_INT_SOURCE  = 6'h30;
  localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
  localparam logic [5:0] REG_DATAX0      = 6'h32;
  localparam logic [5:0] REG_DATAX1      = 6'h33;
  localparam logic [5:0] REG_DATAY0      = 6'h34;
  localparam logic [5:0] REG_DATAY1      = 6'h35;
  localparam logic [5:0] REG_DATAZ0      = 6'h36;
  localparam logic [5:0] REG_DATAZ1      = 6'h37;

  localparam logic [7:0] BW_RATE_50HZ     = 8'h09;
  localparam logic [7:0] FORMAT_FULL_RES  = 8'h08;
  localparam logic [7:0] POWER_MEASURE    = 8'h08;

  localparam int DATA_READY_BIT = 7;
  localparam int INIT_LEN       = 3;
  localparam int READ_LEN       = 6;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] value;
  } init_entry_t;

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_INIT,
    ST_POLL_WAIT,
    ST_STATUS,
    ST_READ,
    ST_PUBLISH
  } ctrl_state_t;

  typedef enum logic [1:0] {
    TXN_IDLE,
    TXN_WAIT_HI,
    TXN_WAIT_LO
  } txn_state_t;

  // Init table, written in order after every startup.
  function automatic init_entry_t init_entry(input logic [1:0] idx);
    init_entry_t e;
    case (idx)
      2'd0:    e = '{addr: REG_BW_RATE,     value: BW_RATE_50HZ};
      2'd1:    e = '{addr: REG_DATA_FORMAT, value: FORMAT_FULL_RES};
      2'd2:    e = '{addr: REG_POWER_CTL,   value: POWER_MEASURE};
      default: e = '{addr: REG_BW_RATE,     value: BW_RATE_50HZ};
    endcase
    return e;
  endfunction

  // Serdes word: [15] read flag, [14] multi-byte (unused), [13:8] address,
  // [7:0] write data, forced to zero on reads.
  function automatic logic [15:0] txn_word(input logic rnw, input logic [5:0] addr,
                                           input logic [7:0] wdata);
    return {rnw, 1'b0, addr, (rnw ? 8'h00 : wdata)};
  endfunction

endpackage

// File: rtl/gsensor_ctrl_if.sv
// Four-phase start/done link between the sequencer and spi_serdes.
interface gsensor_ctrl_if;
  logic [15:0] data_tx;
  logic        start;
  logic        done;
  logic [7:0]  data_rx;

  modport master (output data_tx, output start, input done, input data_rx);
  modport slave  (input data_tx, input start, output done, output data_rx);
endinterface

// File: rtl/gsensor_txn.sv
// One serdes transaction at a time: raise start, hold until done, drop start,
// then wait for done to fall. Either wait is bounded by TIMEOUT_CYCLES.
// ack is a single-cycle strobe in the cycle done is seen high; rdata is
// valid in that same cycle.
module gsensor_txn
  import gsensor_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [5:0] addr,
  input  logic [7:0] wdata,
  input  logic       rnw,
  output logic       ack,
  output logic [7:0] rdata,
  output logic       timeout,
  gsensor_ctrl_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);

  txn_state_t    state;
  txn_state_t    state_next;
  logic [TW-1:0] tcnt;
  logic          launch;

  assign rdata = bus.data_rx;

  // Handshake state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= TXN_IDLE;
    else        state <= state_next;
  end

  // Next-state and strobes; a done seen while idle is ignored.
  always_comb begin
    state_next = state;
    ack        = 1'b0;
    timeout    = 1'b0;
    launch     = 1'b0;
    case (state)
      TXN_IDLE: begin
        if (req) begin
          launch     = 1'b1;
          state_next = TXN_WAIT_HI;
        end
      end
      TXN_WAIT_HI: begin
        if (bus.done) begin
          ack        = 1'b1;
          state_next = TXN_WAIT_LO;
        end else if (tcnt == T_LAST) begin
          timeout    = 1'b1;
          state_next = TXN_IDLE;
        end
      end
      TXN_WAIT_LO: begin
        if (!bus.done) begin
          state_next = TXN_IDLE;
        end else if (tcnt == T_LAST) begin
          timeout    = 1'b1;
          state_next = TXN_IDLE;
        end
      end
      default: state_next = TXN_IDLE;
    endcase
  end

  // start/data_tx drive and the saturating wait counter; reset drops start at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.start   <= 1'b0;
      bus.data_tx <= 16'h0000;
      tcnt        <= '0;
    end else if (launch) begin
      bus.start   <= 1'b1;
      bus.data_tx <= txn_word(rnw, addr, wdata);
      tcnt        <= '0;
    end else if (ack || timeout) begin
      bus.start   <= 1'b0;
      tcnt        <= '0;
    end else if (state != TXN_IDLE && tcnt != T_MAX) begin
      tcnt        <= tcnt + 1'b1;
    end
  end

endmodule

// File: rtl/gsensor_ctrl.sv
// ADXL345 sequencer: startup delay, init table, periodic INT_SOURCE poll and
// six-byte axis read, publishing X/Y/Z with a one-cycle valid strobe.
module gsensor_ctrl
  import gsensor_pkg::*;
#(
  parameter int STARTUP_CYCLES = 4000,
  parameter int POLL_CYCLES    = 40000,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        spi_clk,
  input  logic        reset_n,
  gsensor_ctrl_if.master bus,
  output logic [15:0] data_x,
  output logic [15:0] data_y,
  output logic [15:0] data_z,
  output logic        data_valid,
  output logic        init_done,
  output logic        error
);

  localparam int CNT_MAX = (STARTUP_CYCLES > POLL_CYCLES) ? STARTUP_CYCLES : POLL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] STARTUP_LAST = CW'(STARTUP_CYCLES - 1);
  localparam logic [CW-1:0] POLL_LAST    = CW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT      = CW'(CNT_MAX);
  localparam logic [2:0]    INIT_LAST    = 3'(INIT_LEN - 1);
  localparam logic [2:0]    READ_LAST    = 3'(READ_LEN - 1);

  ctrl_state_t   state;
  ctrl_state_t   state_next;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shadow [5];
  init_entry_t   entry;
  logic          req;
  logic          rnw;
  logic [5:0]    addr;
  logic [7:0]    wdata;
  logic          ack;
  logic [7:0]    rdata;
  logic          timeout;

  gsensor_txn #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_txn (
    .clk     (spi_clk),
    .rst_n   (reset_n),
    .req     (req),
    .addr    (addr),
    .wdata   (wdata),
    .rnw     (rnw),
    .ack     (ack),
    .rdata   (rdata),
    .timeout (timeout),
    .bus     (bus)
  );

  // Sequencer state register.
  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_STARTUP;
    else          state <= state_next;
  end

  // Next state and the transaction request for the current step; any timeout restarts from STARTUP.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    rnw        = 1'b0;
    addr       = REG_INT_SOURCE;
    wdata      = 8'h00;
    entry      = init_entry(idx[1:0]);
    case (state)
      ST_STARTUP: begin
        if (cnt == STARTUP_LAST) state_next = ST_INIT;
      end
      ST_INIT: begin
        req   = 1'b1;
        addr  = entry.addr;
        wdata = entry.value;
        if (ack && idx == INIT_LAST) state_next = ST_POLL_WAIT;
      end
      ST_POLL_WAIT: begin
        if (cnt == POLL_LAST) state_next = ST_STATUS;
      end
      ST_STATUS: begin
        req  = 1'b1;
        rnw  = 1'b1;
        addr = REG_INT_SOURCE;
        if (ack) state_next = rdata[DATA_READY_BIT] ? ST_READ : ST_POLL_WAIT;
      end
      ST_READ: begin
        req  = 1'b1;
        rnw  = 1'b1;
        addr = REG_DATAX0 + 6'(idx);
        if (ack && idx == READ_LAST) state_next = ST_PUBLISH;
      end
      ST_PUBLISH: state_next = ST_POLL_WAIT;
      default:    state_next = ST_STARTUP;
    endcase
    if (timeout) state_next = ST_STARTUP;
  end

  // Counters, shadow bytes and outputs; axis registers load only on the step into PUBLISH.
  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      idx        <= '0;
      for (int i = 0; i < 5; i++) shadow[i] <= 8'h00;
      data_x     <= 16'h0000;
      data_y     <= 16'h0000;
      data_z     <= 16'h0000;
      data_valid <= 1'b0;
      init_done  <= 1'b0;
      error      <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      if (state_next != state)  cnt <= '0;
      else if (cnt != CNT_SAT)  cnt <= cnt + 1'b1;

      if (state_next != state)  idx <= '0;
      else if (ack)             idx <= idx + 1'b1;

      if (state == ST_READ && ack) begin
        for (int i = 0; i < 5; i++) begin
          if (idx == 3'(i)) shadow[i] <= rdata;
        end
        if (idx == READ_LAST) begin
          data_x     <= {shadow[1], shadow[0]};
          data_y     <= {shadow[3], shadow[2]};
          data_z     <= {rdata, shadow[4]};
          data_valid <= 1'b1;
        end
      end

      if (timeout) begin
        init_done <= 1'b0;
        error     <= 1'b1;
      end else if (state == ST_INIT && ack && idx == INIT_LAST) begin
        init_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gsensor_ctrl.sv
// Directed bench for gsensor_ctrl with a scripted serdes stub answering from a
// register image. Shortened startup/poll/timeout counts keep the run short.
module tb_gsensor_ctrl;

  localparam int S = 40;
  localparam int P = 120;
  localparam int T = 20;

  logic        spi_clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] data_x, data_y, data_z;
  logic        data_valid, init_done, error;

  int          errors = 0;
  int          checks = 0;

  logic [7:0]  mem [64];
  bit          stall_en = 1'b0;
  logic [5:0]  stall_addr = 6'h00;
  int          wcnt = 0;
  logic [15:0] tx_log [$];
  int          valid_pulses = 0;
  logic [15:0] cap_x = 16'h0, cap_y = 16'h0, cap_z = 16'h0;
  int          stab_err = 0;
  int          overlap_err = 0;
  logic        prev_start = 1'b0;
  logic [15:0] prev_tx = 16'h0;

  logic [15:0] exp_x [3] = '{16'hA5C3, 16'h8000, 16'h7FFF};
  logic [15:0] exp_y [3] = '{16'h0001, 16'hFFFE, 16'h1357};
  logic [15:0] exp_z [3] = '{16'hC0DE, 16'h0000, 16'hFF80};
  logic [15:0] init_words [3] = '{16'h2C09, 16'h3108, 16'h2D08};

  always #5 spi_clk = ~spi_clk;

  gsensor_ctrl_if bus ();

  gsensor_ctrl #(
    .STARTUP_CYCLES (S),
    .POLL_CYCLES    (P),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .spi_clk    (spi_clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .data_x     (data_x),
    .data_y     (data_y),
    .data_z     (data_z),
    .data_valid (data_valid),
    .init_done  (init_done),
    .error      (error)
  );

  // Serdes stub plus protocol monitor, evaluated on the falling edge.
  always @(negedge spi_clk) begin
    if (!reset_n) begin
      bus.done    = 1'b0;
      bus.data_rx = 8'h00;
      wcnt        = 0;
      prev_start  = 1'b0;
    end else begin
      if (bus.start && prev_start && bus.data_tx !== prev_tx) stab_err++;
      if (bus.start && !prev_start && bus.done) overlap_err++;
      if (data_valid) begin
        valid_pulses++;
        cap_x = data_x;
        cap_y = data_y;
        cap_z = data_z;
      end
      prev_start = bus.start;
      prev_tx    = bus.data_tx;
      if (bus.start && !bus.done) begin
        if (!(stall_en && bus.data_tx[13:8] == stall_addr)) begin
          wcnt++;
          if (wcnt == 2) begin
            bus.done    = 1'b1;
            bus.data_rx = bus.data_tx[15] ? mem[bus.data_tx[13:8]] : 8'h00;
            tx_log.push_back(bus.data_tx);
            wcnt        = 0;
          end
        end
      end else if (bus.done && !bus.start) begin
        bus.done    = 1'b0;
        bus.data_rx = 8'h00;
      end
    end
  end

  task automatic wait_tx(input logic [15:0] word, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge spi_clk); #1;
      if (bus.start && bus.data_tx == word) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_start_level(input logic level, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge spi_clk); #1;
      if (bus.start == level) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_init_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge spi_clk); #1;
      if (init_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_pulses(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge spi_clk); #1;
      if (valid_pulses >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    bit early = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge spi_clk);
    #1;
    checks++; if (bus.start !== 1'b0) begin errors++; $display("[TB] FAIL reset_start: got %b, expected 0", bus.start); end
    checks++; if (bus.data_tx !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data_tx: got %h, expected 0000", bus.data_tx); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, expected 0", data_valid); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_init_done: got %b, expected 0", init_done); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error: got %b, expected 0", error); end
    checks++; if ({data_x, data_y, data_z} !== 48'h0) begin errors++; $display("[TB] FAIL reset_axes: got %h, expected 0", {data_x, data_y, data_z}); end
    tx_log.delete();
    @(negedge spi_clk) reset_n = 1'b1;
    for (int k = 1; k <= S; k++) begin
      @(posedge spi_clk); #1;
      if (bus.start !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("[TB] FAIL startup_quiet: got start during startup, expected none"); end
    @(posedge spi_clk); #1;
    checks++; if (bus.start !== 1'b1) begin errors++; $display("[TB] FAIL first_start: got %b at cycle %0d, expected 1", bus.start, S + 1); end
  endtask

  task automatic test_init;
    bit ok;
    wait_init_done(200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL init_done_rise: got timeout after 200 cycles, expected init_done=1"); end
    checks++; if (tx_log.size() !== 3) begin errors++; $display("[TB] FAIL init_count: got %0d, expected 3", tx_log.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= tx_log.size() || tx_log[i] !== init_words[i]) begin
        errors++;
        $display("[TB] FAIL init_word%0d: got %h, expected %h", i, (i < tx_log.size()) ? tx_log[i] : 16'hxxxx, init_words[i]);
      end
    end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL init_error: got %b, expected 0", error); end
  endtask

  task automatic test_not_ready;
    bit ok;
    int gap = 0;
    wait_tx(16'hB000, P + 100, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL first_status: got no B000 word, expected one"); end
    wait_start_level(1'b0, 20, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL status_end: got start stuck high, expected low"); end
    while (bus.start == 1'b0 && gap < P + 50) begin
      gap++;
      @(posedge spi_clk); #1;
    end
    checks++; if (gap !== P + 1) begin errors++; $display("[TB] FAIL poll_gap: got %0d, expected %0d", gap, P + 1); end
    checks++; if (bus.data_tx !== 16'hB000) begin errors++; $display("[TB] FAIL repoll_word: got %h, expected B000", bus.data_tx); end
    checks++; if (valid_pulses !== 0) begin errors++; $display("[TB] FAIL not_ready_valid: got %0d pulses, expected 0", valid_pulses); end
  endtask

  task automatic test_sample_read;
    bit ok;
    int base = valid_pulses;
    logic [15:0] rd_words [7] = '{16'hB000, 16'hB200, 16'hB300, 16'hB400, 16'hB500, 16'hB600, 16'hB700};
    mem[6'h30] = 8'h80;
    mem[6'h32] = 8'h34; mem[6'h33] = 8'h12;
    mem[6'h34] = 8'hFF; mem[6'h35] = 8'hFF;
    mem[6'h36] = 8'h00; mem[6'h37] = 8'h01;
    tx_log.delete();
    wait_tx(16'hB700, 100, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL last_read: got no B700 word, expected one"); end
    wait_start_level(1'b0, 20, ok);
    checks++; if (data_valid !== 1'b1) begin errors++; $display("[TB] FAIL valid_timing: got %b after 6th done, expected 1", data_valid); end
    checks++; if (data_x !== 16'h1234) begin errors++; $display("[TB] FAIL sample_x: got %h, expected 1234", data_x); end
    checks++; if (data_y !== 16'hFFFF) begin errors++; $display("[TB] FAIL sample_y: got %h, expected FFFF", data_y); end
    checks++; if (data_z !== 16'h0100) begin errors++; $display("[TB] FAIL sample_z: got %h, expected 0100", data_z); end
    @(posedge spi_clk); #1;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL valid_width: got %b, expected 0", data_valid); end
    repeat (10) @(posedge spi_clk);
    #1;
    checks++; if (valid_pulses - base !== 1) begin errors++; $display("[TB] FAIL sample_pulses: got %0d, expected 1", valid_pulses - base); end
    checks++; if (tx_log.size() !== 7) begin errors++; $display("[TB] FAIL read_count: got %0d, expected 7", tx_log.size()); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= tx_log.size() || tx_log[i] !== rd_words[i]) begin
        errors++;
        $display("[TB] FAIL read_word%0d: got %h, expected %h", i, (i < tx_log.size()) ? tx_log[i] : 16'hxxxx, rd_words[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int base = valid_pulses;
    for (int p = 0; p < 3; p++) begin
      mem[6'h32] = exp_x[p][7:0]; mem[6'h33] = exp_x[p][15:8];
      mem[6'h34] = exp_y[p][7:0]; mem[6'h35] = exp_y[p][15:8];
      mem[6'h36] = exp_z[p][7:0]; mem[6'h37] = exp_z[p][15:8];
      wait_pulses(base + p + 1, P + 150, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_pulse%0d: got no pulse, expected one", p); end
      checks++; if ({cap_x, cap_y, cap_z} !== {exp_x[p], exp_y[p], exp_z[p]}) begin
        errors++;
        $display("[TB] FAIL b2b_sample%0d: got %h %h %h, expected %h %h %h", p, cap_x, cap_y, cap_z, exp_x[p], exp_y[p], exp_z[p]);
      end
    end
    repeat (10) @(posedge spi_clk);
    #1;
    checks++; if (valid_pulses - base !== 3) begin errors++; $display("[TB] FAIL b2b_count: got %0d, expected 3", valid_pulses - base); end
    checks++; if (stab_err !== 0) begin errors++; $display("[TB] FAIL tx_stable: got %0d changes, expected 0", stab_err); end
    checks++; if (overlap_err !== 0) begin errors++; $display("[TB] FAIL start_overlap: got %0d, expected 0", overlap_err); end
  endtask

  task automatic test_timeout;
    bit ok;
    int hi = 0;
    mem[6'h32] = 8'h55; mem[6'h33] = 8'h66;
    stall_en   = 1'b1;
    stall_addr = 6'h34;
    wait_tx(16'hB400, P + 100, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL stall_read: got no B400 word, expected one"); end
    while (bus.start == 1'b1 && hi < T + 10) begin
      hi++;
      @(posedge spi_clk); #1;
    end
    checks++; if (hi !== T) begin errors++; $display("[TB] FAIL timeout_len: got %0d cycles, expected %0d", hi, T); end
    checks++; if (bus.start !== 1'b0) begin errors++; $display("[TB] FAIL timeout_start: got %b, expected 0", bus.start); end
    checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL timeout_error: got %b, expected 1", error); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("[TB] FAIL timeout_init_done: got %b, expected 0", init_done); end
    checks++; if ({data_x, data_y, data_z} !== {exp_x[2], exp_y[2], exp_z[2]}) begin
      errors++;
      $display("[TB] FAIL timeout_hold: got %h %h %h, expected %h %h %h", data_x, data_y, data_z, exp_x[2], exp_y[2], exp_z[2]);
    end
    stall_en = 1'b0;
    tx_log.delete();
    wait_init_done(S + 200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL reinit: got no init_done, expected 1"); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= tx_log.size() || tx_log[i] !== init_words[i]) begin
        errors++;
        $display("[TB] FAIL reinit_word%0d: got %h, expected %h", i, (i < tx_log.size()) ? tx_log[i] : 16'hxxxx, init_words[i]);
      end
    end
    checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL error_sticky: got %b, expected 1", error); end
  endtask

  task automatic test_mid_reset;
    bit ok;
    mem[6'h30] = 8'h00;
    wait_start_level(1'b1, P + 100, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL mid_start: got no start, expected one"); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.start !== 1'b0) begin errors++; $display("[TB] FAIL mid_start_drop: got %b, expected 0", bus.start); end
    checks++; if (bus.data_tx !== 16'h0000) begin errors++; $display("[TB] FAIL mid_data_tx: got %h, expected 0000", bus.data_tx); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL mid_error: got %b, expected 0", error); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_init_done: got %b, expected 0", init_done); end
    checks++; if ({data_x, data_y, data_z, data_valid} !== 49'h0) begin
      errors++;
      $display("[TB] FAIL mid_outputs: got %h %h %h %b, expected zeros", data_x, data_y, data_z, data_valid);
    end
    repeat (3) @(negedge spi_clk);
    tx_log.delete();
    reset_n = 1'b1;
    wait_init_done(S + 200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL mid_reinit: got no init_done, expected 1"); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= tx_log.size() || tx_log[i] !== init_words[i]) begin
        errors++;
        $display("[TB] FAIL mid_word%0d: got %h, expected %h", i, (i < tx_log.size()) ? tx_log[i] : 16'hxxxx, init_words[i]);
      end
    end
  endtask

  initial begin
    bus.done    = 1'b0;
    bus.data_rx = 8'h00;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    $display("[TB] gsensor_ctrl bench start");
    test_reset;
    test_init;
    test_not_ready;
    test_sample_read;
    test_back_to_back;
    test_timeout;
    test_mid_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
